// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared encodings and constants for the Keccak round controller
package keccak_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_t;

    localparam int KECCAK_ROUNDS = 24;
    localparam int RW            = 5;

    // A single-slot loop still needs a 1-bit slot port.
    function automatic int slot_width(input int nstage);
        return (nstage > 1) ? $clog2(nstage) : 1;
    endfunction

endpackage

// File: rtl/keccak_slot_round_cnt.sv
// rtl/keccak_slot_round_cnt.sv - slot/round counter pair for the interleaved round loop
module keccak_slot_round_cnt #(
    parameter int NSTAGE = 2,
    parameter int ROUNDS = 24,
    parameter int SW     = 1,
    parameter int RW     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_step,
    input  logic          i_round_en,
    output logic [SW-1:0] o_slot,
    output logic [RW-1:0] o_round,
    output logic          o_slot_last,
    output logic          o_round_last,
    output logic          o_wrap
);

    localparam logic [SW-1:0] SLOT_MAX  = SW'(NSTAGE - 1);
    localparam logic [RW-1:0] ROUND_MAX = RW'(ROUNDS - 1);

    logic [SW-1:0] r_slot;
    logic [RW-1:0] r_round;
    logic          w_slot_last;
    logic          w_round_last;

    assign w_slot_last  = (r_slot == SLOT_MAX);
    assign w_round_last = (r_round == ROUND_MAX);

    assign o_slot       = r_slot;
    assign o_round      = r_round;
    assign o_slot_last  = w_slot_last;
    assign o_round_last = w_round_last;
    assign o_wrap       = w_slot_last & w_round_last;

    // Round only advances while running; during fill the slot wrap leaves round at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot  <= '0;
            r_round <= '0;
        end else if (i_step) begin
            if (w_slot_last) begin
                r_slot <= '0;
                if (i_round_en && !w_round_last) begin
                    r_round <= r_round + RW'(1);
                end else begin
                    r_round <= '0;
                end
            end else begin
                r_slot <= r_slot + SW'(1);
            end
        end
    end

endmodule

// File: rtl/keccak_round_ctrl_np.sv
// rtl/keccak_round_ctrl_np.sv - fill/run sequencer for an NSTAGE-way interleaved Keccak-f round loop
module keccak_round_ctrl_np
    import keccak_pkg::*;
#(
    parameter int  NSTAGE = 2,
    parameter int  ROUNDS = KECCAK_ROUNDS,
    localparam int SW     = slot_width(NSTAGE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          last_block,
    output logic          in_ready,
    output logic          load,
    output logic          k,
    output logic          en,
    output logic          up,
    output logic [SW-1:0] slot,
    output logic [RW-1:0] round,
    output logic          out_valid,
    output logic          busy
);

    ctrl_state_t   r_state;
    logic          r_last_q;
    logic          r_last_nxt;

    logic          w_fill;
    logic          w_run;
    logic [SW-1:0] w_slot;
    logic [RW-1:0] w_round;
    logic          w_slot_first;
    logic          w_slot_last;
    logic          w_round_last;
    logic          w_wrap;
    logic          w_new_last;

    keccak_slot_round_cnt #(
        .NSTAGE (NSTAGE),
        .ROUNDS (ROUNDS),
        .SW     (SW),
        .RW     (RW)
    ) u_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_step       (en),
        .i_round_en   (w_run),
        .o_slot       (w_slot),
        .o_round      (w_round),
        .o_slot_last  (w_slot_last),
        .o_round_last (w_round_last),
        .o_wrap       (w_wrap)
    );

    assign w_fill       = (r_state == ST_FILL);
    assign w_run        = (r_state == ST_RUN);
    assign w_slot_first = (w_slot == '0);

    // With one slot the final-flag beat and the pass boundary coincide, so take last_block directly.
    assign w_new_last   = w_slot_first ? last_block : r_last_nxt;

    // In fill the loop only moves on accepted beats; in run it only stops for a missing absorb beat.
    assign in_ready  = w_fill | (w_round_last & ~r_last_q);
    assign load      = in_valid & in_ready;
    assign k         = w_fill & load;
    assign en        = ~(in_ready & ~in_valid);
    assign up        = w_run & en & w_slot_last;
    assign out_valid = w_run & w_round_last & r_last_q;
    assign busy      = ~(w_fill & w_slot_first);
    assign slot      = w_slot;
    assign round     = w_round;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FILL;
            r_last_q   <= 1'b0;
            r_last_nxt <= 1'b0;
        end else begin
            if (load && w_slot_first) begin
                r_last_nxt <= last_block;
            end
            if (r_state == ST_FILL) begin
                if (en && w_slot_last) begin
                    r_state  <= ST_RUN;
                    r_last_q <= w_new_last;
                end
            end else if (en && w_wrap) begin
                if (r_last_q) begin
                    r_state <= ST_FILL;
                end else begin
                    r_last_q <= w_new_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_keccak_round_ctrl_np.sv
// tb/tb_keccak_round_ctrl_np.sv - self-checking bench for keccak_round_ctrl_np
`timescale 1ns/1ps
module tb_keccak_round_ctrl_np;

    typedef struct {
        bit run;
        int cnt;
        bit lcur;
        bit lnext;
    } mst_t;

    typedef struct {
        int slot;
        int rnd;
        bit in_ready;
        bit load;
        bit k;
        bit en;
        bit up;
        bit out_valid;
        bit busy;
    } mout_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_iv, a_lb, a_in_ready, a_load, a_k, a_en, a_up, a_out_valid, a_busy;
    logic [0:0] a_slot;
    logic [4:0] a_round;
    logic       b_iv, b_lb, b_in_ready, b_load, b_k, b_en, b_up, b_out_valid, b_busy;
    logic [0:0] b_slot;
    logic [4:0] b_round;
    logic       c_iv, c_lb, c_in_ready, c_load, c_k, c_en, c_up, c_out_valid, c_busy;
    logic [1:0] c_slot;
    logic [4:0] c_round;

    keccak_round_ctrl_np #(.NSTAGE(2), .ROUNDS(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .last_block(a_lb),
        .in_ready(a_in_ready), .load(a_load), .k(a_k), .en(a_en), .up(a_up),
        .slot(a_slot), .round(a_round), .out_valid(a_out_valid), .busy(a_busy));

    keccak_round_ctrl_np #(.NSTAGE(1), .ROUNDS(24)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .last_block(b_lb),
        .in_ready(b_in_ready), .load(b_load), .k(b_k), .en(b_en), .up(b_up),
        .slot(b_slot), .round(b_round), .out_valid(b_out_valid), .busy(b_busy));

    keccak_round_ctrl_np #(.NSTAGE(3), .ROUNDS(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .last_block(c_lb),
        .in_ready(c_in_ready), .load(c_load), .k(c_k), .en(c_en), .up(c_up),
        .slot(c_slot), .round(c_round), .out_valid(c_out_valid), .busy(c_busy));

    int   n_checks = 0;
    int   n_err    = 0;
    int   tcyc     = 0;
    bit   chk_en   = 1'b0;
    mst_t ma, mb, mc;
    int   a_ov_q[$], a_up_q[$], a_k_q[$], b_ov_q[$], b_up_q[$], c_ov_q[$], c_up_q[$];

    // Model: a fill counts accepted beats; a pass counts productive cycles, so slot=cnt%n, round=cnt/n.
    function automatic mout_t model_out(input mst_t s, input int n, input int r, input bit iv);
        mout_t o;
        bit    fin;
        o = '{default: 0};
        if (!s.run) begin
            o.slot     = s.cnt;
            o.in_ready = 1'b1;
            o.load     = iv;
            o.k        = iv;
            o.en       = iv;
            o.busy     = (s.cnt != 0);
        end else begin
            fin         = (s.cnt >= (r - 1) * n);
            o.slot      = s.cnt % n;
            o.rnd       = s.cnt / n;
            o.in_ready  = fin && !s.lcur;
            o.en        = !(o.in_ready && !iv);
            o.load      = iv && o.in_ready;
            o.up        = o.en && (o.slot == n - 1);
            o.out_valid = fin && s.lcur;
            o.busy      = 1'b1;
        end
        return o;
    endfunction

    function automatic mst_t model_next(input mst_t s, input int n, input int r, input bit iv, input bit lb);
        mst_t  t;
        mout_t o;
        t = s;
        o = model_out(s, n, r, iv);
        if (o.load && o.slot == 0) t.lnext = lb;
        if (o.en) begin
            t.cnt = s.cnt + 1;
            if (!s.run && t.cnt == n) begin
                t.run  = 1'b1;
                t.cnt  = 0;
                t.lcur = t.lnext;
            end else if (s.run && t.cnt == r * n) begin
                t.cnt = 0;
                if (s.lcur) t.run = 1'b0;
                else        t.lcur = t.lnext;
            end
        end
        return t;
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -100000;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, tcyc, act, exp);
        end
    endtask

    task automatic check_inst(input string tg, input mout_t e,
                              input logic [31:0] slot_a, input logic [31:0] rnd_a,
                              input logic rdy, input logic ld, input logic kk, input logic ena,
                              input logic upp, input logic ov, input logic bsy);
        cmp({tg, ".slot"},      slot_a,     e.slot);
        cmp({tg, ".round"},     rnd_a,      e.rnd);
        cmp({tg, ".in_ready"},  32'(rdy),   32'(e.in_ready));
        cmp({tg, ".load"},      32'(ld),    32'(e.load));
        cmp({tg, ".k"},         32'(kk),    32'(e.k));
        cmp({tg, ".en"},        32'(ena),   32'(e.en));
        cmp({tg, ".up"},        32'(upp),   32'(e.up));
        cmp({tg, ".out_valid"}, 32'(ov),    32'(e.out_valid));
        cmp({tg, ".busy"},      32'(bsy),   32'(e.busy));
    endtask

    task automatic check_list(input string nm, input int q[$], input int base, input int t0,
                              input int n_exp, input int first_exp, input int last_exp);
        cmp({nm, ".count"}, q.size() - base, n_exp);
        cmp({nm, ".first"}, qat(q, base) - t0, first_exp);
        cmp({nm, ".last"},  qat(q, q.size() - 1) - t0, last_exp);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
            mc <= '{default: 0};
        end else begin
            ma <= model_next(ma, 2, 24, a_iv, a_lb);
            mb <= model_next(mb, 1, 24, b_iv, b_lb);
            mc <= model_next(mc, 3, 4, c_iv, c_lb);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst("A", model_out(ma, 2, 24, a_iv), 32'(a_slot), 32'(a_round),
                       a_in_ready, a_load, a_k, a_en, a_up, a_out_valid, a_busy);
            check_inst("B", model_out(mb, 1, 24, b_iv), 32'(b_slot), 32'(b_round),
                       b_in_ready, b_load, b_k, b_en, b_up, b_out_valid, b_busy);
            check_inst("C", model_out(mc, 3, 4, c_iv), 32'(c_slot), 32'(c_round),
                       c_in_ready, c_load, c_k, c_en, c_up, c_out_valid, c_busy);
            if (a_out_valid) a_ov_q.push_back(tcyc);
            if (a_up)        a_up_q.push_back(tcyc);
            if (a_k)         a_k_q.push_back(tcyc);
            if (b_out_valid) b_ov_q.push_back(tcyc);
            if (b_up)        b_up_q.push_back(tcyc);
            if (c_out_valid) c_ov_q.push_back(tcyc);
            if (c_up)        c_up_q.push_back(tcyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tcyc++;
    endtask

    task automatic run_single(input string tg);
        int t0, ov0, up0;
        t0  = tcyc;
        ov0 = a_ov_q.size();
        up0 = a_up_q.size();
        for (int c = 0; c < 52; c++) begin
            a_iv = (c < 2);
            a_lb = 1'b1;
            #1;
            if (c == 49) begin
                cmp({tg, ".round49"}, 32'(a_round), 23);
                cmp({tg, ".slot49"},  32'(a_slot), 1);
            end
            if (c == 50) begin
                cmp({tg, ".ready50"}, 32'(a_in_ready), 1);
                cmp({tg, ".busy50"},  32'(a_busy), 0);
            end
            tick();
        end
        a_iv = 1'b0;
        check_list({tg, ".ov"}, a_ov_q, ov0, t0, 2, 48, 49);
        check_list({tg, ".up"}, a_up_q, up0, t0, 24, 3, 49);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", tcyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ov0, up0, k0, ovb, upb, ovc, upc;
        a_iv = 0; a_lb = 0; b_iv = 0; b_lb = 0; c_iv = 0; c_lb = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        #1;
        cmp("rst.in_ready",  32'(a_in_ready), 1);
        cmp("rst.busy",      32'(a_busy), 0);
        cmp("rst.en",        32'(a_en), 0);
        cmp("rst.out_valid", 32'(a_out_valid), 0);
        cmp("rst.slot",      32'(a_slot), 0);
        tick();
        tick();

        run_single("S1");
        tick();

        // Two-block message, re-absorb in the final round of the first pass.
        t0 = tcyc; ov0 = a_ov_q.size(); k0 = a_k_q.size();
        for (int c = 0; c < 100; c++) begin
            a_iv = (c < 2) || (c == 48) || (c == 49);
            a_lb = (c >= 48);
            #1;
            if (c == 48 || c == 49) begin
                cmp("S2.ready", 32'(a_in_ready), 1);
                cmp("S2.load",  32'(a_load), 1);
                cmp("S2.k",     32'(a_k), 0);
            end
            tick();
        end
        a_iv = 1'b0;
        check_list("S2.ov", a_ov_q, ov0, t0, 2, 96, 97);
        check_list("S2.k",  a_k_q,  k0,  t0, 2, 0, 1);

        // Fill bubble at cycle 1.
        t0 = tcyc; ov0 = a_ov_q.size();
        for (int c = 0; c < 53; c++) begin
            a_iv = (c == 0) || (c == 2);
            a_lb = 1'b1;
            #1;
            if (c == 1) cmp("S3.en1", 32'(a_en), 0);
            if (c == 2) cmp("S3.slot2", 32'(a_slot), 1);
            tick();
        end
        a_iv = 1'b0;
        check_list("S3.ov", a_ov_q, ov0, t0, 2, 49, 50);

        // Missing absorb beat at cycle 49 stalls the loop.
        t0 = tcyc; ov0 = a_ov_q.size();
        for (int c = 0; c < 101; c++) begin
            a_iv = (c < 2) || (c == 48) || (c == 50);
            a_lb = (c >= 48);
            #1;
            if (c == 49) begin
                cmp("S4.en49",    32'(a_en), 0);
                cmp("S4.slot49",  32'(a_slot), 1);
                cmp("S4.round49", 32'(a_round), 23);
            end
            tick();
        end
        a_iv = 1'b0;
        check_list("S4.ov", a_ov_q, ov0, t0, 2, 97, 98);

        // Reset in the middle of a run.
        ov0 = a_ov_q.size();
        for (int c = 0; c < 20; c++) begin
            a_iv = (c < 2);
            a_lb = 1'b1;
            tick();
        end
        a_iv = 1'b0;
        #1;
        cmp("S5.busy_pre", 32'(a_busy), 1);
        rst_n = 1'b0;
        #1;
        cmp("S5.out_valid", 32'(a_out_valid), 0);
        cmp("S5.slot",      32'(a_slot), 0);
        cmp("S5.round",     32'(a_round), 0);
        cmp("S5.busy",      32'(a_busy), 0);
        cmp("S5.in_ready",  32'(a_in_ready), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        cmp("S5.no_ov", a_ov_q.size() - ov0, 0);
        run_single("S5b");

        // Parameter sweep: NSTAGE=1/ROUNDS=24 and NSTAGE=3/ROUNDS=4.
        t0 = tcyc;
        ovb = b_ov_q.size(); upb = b_up_q.size();
        ovc = c_ov_q.size(); upc = c_up_q.size();
        for (int c = 0; c < 40; c++) begin
            b_iv = (c == 0);
            b_lb = 1'b1;
            c_iv = (c < 3);
            c_lb = 1'b1;
            tick();
        end
        b_iv = 1'b0;
        c_iv = 1'b0;
        check_list("S6.b_ov", b_ov_q, ovb, t0, 1, 24, 24);
        check_list("S6.b_up", b_up_q, upb, t0, 24, 1, 24);
        check_list("S6.c_ov", c_ov_q, ovc, t0, 3, 12, 14);
        check_list("S6.c_up", c_up_q, upc, t0, 4, 5, 14);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/keccak_round_ctrl_np.md
Name: keccak_round_ctrl_np

Overview:
Parametrised control FSM for an N-way interleaved Keccak-f round datapath. NSTAGE independent states circulate through an NSTAGE-deep pipelined round loop, one slot per cycle. The block sequences fill, ROUNDS round passes, multi-block re-absorb with a valid/ready handshake and pipeline stall, and result hand-off. It drives the state-register load/clear controls, the round-constant counter and the pipeline enable.

Parameters:
NSTAGE, 2, interleaved slots = pipeline depth of the round loop; legal 1..8
ROUNDS, 24, rounds per permutation; legal 2..31
SW, derived localparam = max(1, clog2(NSTAGE)), slot index width
RW, derived localparam = 5, round index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  absorb block presented for current slot
last_block  in  1  group's current block is final; sampled only on the slot-0 beat
in_ready  out  1  block accepted this cycle if in_valid
load  out  1  = in_valid & in_ready; datapath loads/XORs block into current slot
k  out  1  clear slot state before load (new message)
en  out  1  pipeline advance enable
up  out  1  round-constant counter increment pulse
slot  out  SW  slot currently at the loop input
round  out  RW  round index of current pass
out_valid  out  1  slot's digest state is final this cycle
busy  out  1  high unless in FILL with slot==0

Behaviour:
- States: FILL, RUN. Registers: state, slot, round, last_q, last_nxt.
- Reset (async, rst_n=0): state=FILL, slot=0, round=0, last_q=0, last_nxt=0. Resulting outputs: in_ready=1, load/k/up/en/out_valid=0 (with in_valid=0), busy=0. Reset mid-operation discards all in-flight slots; no out_valid is produced for them.
- FILL: in_ready=1; k=load; en=load. Each accepted beat: slot++. On the slot-0 beat, last_nxt<=last_block. Without in_valid, the block holds (bubble) and slot does not move.
- FILL, accepted beat at slot==NSTAGE-1: go RUN; slot=0, round=0, last_q<=last_nxt. If NSTAGE==1, last_q takes last_block from that same beat.
- RUN: k=0. in_ready=(round==ROUNDS-1)&~last_q. en=~(in_ready&~in_valid), so a missing absorb beat stalls the whole loop: slot, round and state all hold.
- RUN, en=1: slot wraps modulo NSTAGE. up=1 when slot==NSTAGE-1, once per round, ROUNDS pulses per pass.
- RUN, en=1, slot==NSTAGE-1, round<ROUNDS-1: round++.
- RUN, en=1, slot==NSTAGE-1, round==ROUNDS-1:
  - last_q=1: go FILL, slot=0, round=0.
  - last_q=0: stay RUN, round=0, last_q<=last_nxt.
- RUN re-absorb: on an accepted slot-0 beat, last_nxt<=last_block. The new value does not affect last_q until the pass wrap.
- out_valid=(state==RUN)&(round==ROUNDS-1)&last_q. It is never stalled, because in_ready=0 there.
- busy=~(state==FILL & slot==0).
- Latency: first beat at cycle t; NSTAGE beats with no bubbles; RUN starts at t+NSTAGE; out_valid for slot s at t+NSTAGE+(ROUNDS-1)*NSTAGE+s; in_ready returns high the following cycle.
- All outputs are combinational from registered state plus in_valid only. No combinational path from last_block.

Decomposition:
- Shared package keccak_pkg: state encodings (FILL, RUN), KECCAK_ROUNDS=24, RW=5.
- Optional sub-module keccak_slot_round_cnt: slot/round counter pair with enable and wrap flag. The FSM stays in this top module.

Test Plan:
- Single block, NSTAGE=2, ROUNDS=24, beats at cycles 0,1 with last_block=1:
  - RUN runs cycles 2..49.
  - up pulses on cycles 3,5,...,49 (24 pulses).
  - out_valid at cycles 48 (slot 0) and 49 (slot 1).
  - in_ready=1 and busy=0 at cycle 50.
- Two-block message, first group with last_block=0:
  - in_ready=1 at cycles 48,49; load=1 with k=0 on both.
  - Second group last_block=1 gives out_valid at cycles 96,97.
  - k=1 only on cycles 0,1.
- FILL bubble: in_valid low at cycle 1, high at cycle 2:
  - slot holds at 1; RUN starts cycle 3.
  - out_valid at cycles 49,50.
- Absorb stall: in_valid low at cycle 49 of a non-last pass:
  - en=0, slot=1, round=23 held.
  - Accepted at cycle 50; the second pass shifts by one cycle (out_valid at 97,98).
- Reset mid-RUN: rst_n low at cycle 20:
  - Immediately state=FILL, slot=0, round=0, out_valid=0, busy=0.
  - Fresh single-block run afterwards matches the first scenario's timing.
- Parameter sweep NSTAGE=1/ROUNDS=24 and NSTAGE=3/ROUNDS=4 with single block:
  - out_valid count equals NSTAGE.
  - up pulses equal ROUNDS.
  - First out_valid at t+NSTAGE+(ROUNDS-1)*NSTAGE.
